// File: rtl/ioctl_sdram_loader_if.sv
// SDRAM loader-port write bus: a req/ack handshake carrying word address,
// 16-bit data and byte enables. The loader is the master.
interface ioctl_sdram_loader_if;
  logic        sdram_req;
  logic [23:0] sdram_addr;
  logic [15:0] sdram_din;
  logic [1:0]  sdram_be;
  logic        sdram_ack;

  modport master (
    output sdram_req,
    output sdram_addr,
    output sdram_din,
    output sdram_be,
    input  sdram_ack
  );

  modport slave (
    input  sdram_req,
    input  sdram_addr,
    input  sdram_din,
    input  sdram_be,
    output sdram_ack
  );
endinterface

// File: rtl/ioctl_sdram_loader.sv
// Download-to-SDRAM loader: packs ioctl bytes into 16-bit little-endian words
// with byte enables, buffers them in a small FIFO and writes them to SDRAM via
// a req/ack handshake. clkref_n throttles the download stage so no byte is lost.
module ioctl_sdram_loader #(
  parameter int          DEPTH     = 4,
  parameter logic [23:0] BASE_WORD = 24'h000000,
  parameter logic [5:0]  INDEX     = 6'h3F
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        ioctl_download,
  input  logic [7:0]                  ioctl_index,
  input  logic                        ioctl_wr,
  input  logic [26:0]                 ioctl_addr,
  input  logic [7:0]                  ioctl_dout,
  output logic                        clkref_n,
  ioctl_sdram_loader_if.master        sdram,
  output logic                        loader_busy,
  output logic                        loader_done,
  output logic                        overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] FREE2_LIM = CW'(DEPTH - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] din;
    logic [1:0]  be;
  } wr_word_t;

  // Word address of a download byte; wraps modulo 2^24.
  function automatic logic [23:0] word_addr(input logic [26:0] byte_addr);
    return BASE_WORD + byte_addr[24:1];
  endfunction

  state_t           state, state_nxt;
  logic             download_p1;
  logic             start_hold;
  logic             dl_rise;
  logic             idx_ok;
  logic             byte_acc;
  logic [23:0]      byte_waddr;

  logic             pend_vld;
  logic [23:0]      pend_addr;
  logic [7:0]       pend_byte;
  logic             pend_load;
  logic             pend_clr;

  logic             push_req;
  logic             push_ok;
  logic             push_drop;
  logic             order_err;
  wr_word_t         push_word;
  logic             flush_push;

  wr_word_t         mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             fifo_full;
  logic             fifo_empty;
  wr_word_t         head_word;
  logic             pop;

  logic             req_q;
  logic [23:0]      addr_q;
  logic [15:0]      din_q;
  logic [1:0]       be_q;
  logic             done_q;
  logic             ovf_q;
  logic             drain_ok;

  logic             unused_bits;
  assign unused_bits = ^{ioctl_addr[26:25], ioctl_index[7:6]};

  assign dl_rise    = ioctl_download & ~download_p1;
  assign idx_ok     = (INDEX == 6'h3F) || (ioctl_index[5:0] == INDEX);
  assign byte_acc   = ioctl_wr & ioctl_download & idx_ok & (state == S_LOAD);
  assign byte_waddr = word_addr(ioctl_addr);

  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  assign head_word  = mem[rd_ptr];
  assign pop        = req_q & sdram.sdram_ack;
  assign drain_ok   = fifo_empty & ~req_q;
  assign flush_push = (state == S_FLUSH) & pend_vld & ~fifo_full;
  assign push_ok    = push_req & ~fifo_full;
  assign push_drop  = push_req & fifo_full;

  // Download edge detect and a start request held while the previous file drains.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      download_p1 <= 1'b0;
      start_hold  <= 1'b0;
    end else begin
      download_p1 <= ioctl_download;
      if (state == S_IDLE)
        start_hold <= 1'b0;
      else if (dl_rise && (state == S_FLUSH || state == S_DRAIN))
        start_hold <= 1'b1;
    end
  end

  // Byte packer: decide what (if anything) is pushed and how the pending byte changes.
  always_comb begin
    push_req  = 1'b0;
    push_word = '0;
    pend_load = 1'b0;
    pend_clr  = 1'b0;
    order_err = 1'b0;
    if (byte_acc) begin
      if (!ioctl_addr[0]) begin
        pend_load = 1'b1;
        if (pend_vld) begin
          push_req  = 1'b1;
          push_word = {pend_addr, 8'h00, pend_byte, 2'b01};
        end
      end else if (pend_vld) begin
        pend_clr = 1'b1;
        push_req = 1'b1;
        if (pend_addr == byte_waddr) begin
          push_word = {pend_addr, ioctl_dout, pend_byte, 2'b11};
        end else begin
          // Odd byte for a different word: keep the even byte, drop the odd one.
          push_word = {pend_addr, 8'h00, pend_byte, 2'b01};
          order_err = 1'b1;
        end
      end else begin
        push_req  = 1'b1;
        push_word = {byte_waddr, ioctl_dout, 8'h00, 2'b10};
      end
    end else if (flush_push) begin
      push_req  = 1'b1;
      push_word = {pend_addr, 8'h00, pend_byte, 2'b01};
      pend_clr  = 1'b1;
    end
  end

  // Pending-byte valid flag.
  always_ff @(posedge clk_sys) begin
    if (reset)
      pend_vld <= 1'b0;
    else if (pend_load)
      pend_vld <= 1'b1;
    else if (pend_clr)
      pend_vld <= 1'b0;
  end

  // Pending-byte address and data (no reset needed; qualified by pend_vld).
  always_ff @(posedge clk_sys) begin
    if (pend_load) begin
      pend_addr <= byte_waddr;
      pend_byte <= ioctl_dout;
    end
  end

  // FIFO storage; writes only when there is room.
  always_ff @(posedge clk_sys) begin
    if (push_ok)
      mem[wr_ptr] <= push_word;
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave the count unchanged.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // SDRAM request: load the FIFO head when idle, hold it stable until ack.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      be_q   <= '0;
    end else if (req_q) begin
      if (sdram.sdram_ack)
        req_q <= 1'b0;
    end else if (!fifo_empty) begin
      req_q  <= 1'b1;
      addr_q <= head_word.addr;
      din_q  <= head_word.din;
      be_q   <= head_word.be;
    end
  end

  assign sdram.sdram_req  = req_q;
  assign sdram.sdram_addr = addr_q;
  assign sdram.sdram_din  = din_q;
  assign sdram.sdram_be   = be_q;

  // Sticky overflow: dropped push or illegal byte ordering.
  always_ff @(posedge clk_sys) begin
    if (reset)
      ovf_q <= 1'b0;
    else if (push_drop || order_err)
      ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;

  // Completion pulse on the DRAIN -> IDLE transition.
  always_ff @(posedge clk_sys) begin
    if (reset)
      done_q <= 1'b0;
    else
      done_q <= (state == S_DRAIN) && drain_ok;
  end

  assign loader_done = done_q;

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (dl_rise || start_hold) state_nxt = S_LOAD;
      S_LOAD:  if (!ioctl_download)       state_nxt = S_FLUSH;
      S_FLUSH: if (!pend_vld || !fifo_full) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_ok)              state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: throttle needs room for two words (byte in flight plus one more).
  always_comb begin
    loader_busy = (state != S_IDLE);
    clkref_n    = 1'b1;
    if (state == S_LOAD && count <= FREE2_LIM)
      clkref_n = 1'b0;
  end

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Bench for ioctl_sdram_loader: two instances (default parameters and
// BASE_WORD=0x100000/INDEX=2) share the download inputs through a select;
// an SDRAM responder compares every write against a scoreboard queue.
module tb_ioctl_sdram_loader;

  typedef struct packed {
    logic [23:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } exp_t;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset;
  logic        dl, wr, sel;
  logic [7:0]  idx, dout;
  logic [26:0] addr;
  logic        ack_r, ack_m;
  logic        clkref_a, clkref_b, busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;

  ioctl_sdram_loader_if bus_a ();
  ioctl_sdram_loader_if bus_b ();

  ioctl_sdram_loader #(.DEPTH(4)) dut_a (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (dl & ~sel),
    .ioctl_index    (idx),
    .ioctl_wr       (wr & ~sel),
    .ioctl_addr     (addr),
    .ioctl_dout     (dout),
    .clkref_n       (clkref_a),
    .sdram          (bus_a),
    .loader_busy    (busy_a),
    .loader_done    (done_a),
    .overflow       (ovf_a)
  );

  ioctl_sdram_loader #(.DEPTH(4), .BASE_WORD(24'h100000), .INDEX(6'h02)) dut_b (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (dl & sel),
    .ioctl_index    (idx),
    .ioctl_wr       (wr & sel),
    .ioctl_addr     (addr),
    .ioctl_dout     (dout),
    .clkref_n       (clkref_b),
    .sdram          (bus_b),
    .loader_busy    (busy_b),
    .loader_done    (done_b),
    .overflow       (ovf_b)
  );

  assign bus_a.sdram_ack = (ack_r | ack_m) & ~sel;
  assign bus_b.sdram_ack = (ack_r | ack_m) & sel;

  wire        clkref_m = sel ? clkref_b : clkref_a;
  wire        req_m    = sel ? bus_b.sdram_req : bus_a.sdram_req;
  wire [23:0] addr_m   = sel ? bus_b.sdram_addr : bus_a.sdram_addr;
  wire [15:0] din_m    = sel ? bus_b.sdram_din : bus_a.sdram_din;
  wire [1:0]  be_m     = sel ? bus_b.sdram_be : bus_a.sdram_be;
  wire        busy_m   = sel ? busy_b : busy_a;
  wire        done_m   = sel ? done_b : done_a;
  wire        ovf_m    = sel ? ovf_b : ovf_a;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  int   wr_cnt = 0, done_cnt = 0;
  int   wr_base, done_base;
  int   ack_delay;
  bit   ack_hold;

  bit          m_vld, m_accept;
  logic [23:0] m_addr, m_base;
  logic [7:0]  m_byte;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_sys) if (done_m === 1'b1) done_cnt++;

  // SDRAM responder: acks each request after ack_delay cycles (plus any hold).
  int   rsp_n;
  bit   rsp_ok;
  exp_t rsp_e;
  initial begin
    ack_r = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      if (req_m === 1'b1) begin
        rsp_n  = 0;
        rsp_ok = 1'b1;
        while ((ack_hold || rsp_n < ack_delay) && rsp_ok) begin
          @(posedge clk_sys); #1;
          if (!ack_hold) rsp_n++;
          if (req_m !== 1'b1) rsp_ok = 1'b0;
        end
        if (rsp_ok) begin
          check_eq("wr_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            rsp_e = exp_q.pop_front();
            check_eq("wr_addr", 64'(addr_m), 64'(rsp_e.a));
            check_eq("wr_din", 64'(din_m), 64'(rsp_e.d));
            check_eq("wr_be", 64'(be_m), 64'(rsp_e.be));
          end
          wr_cnt++;
          ack_r = 1'b1;
          @(posedge clk_sys); #1;
          ack_r = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    dl = 1'b0;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic begin_test();
    wr_base   = wr_cnt;
    done_base = done_cnt;
    exp_q.delete();
    m_vld = 1'b0;
  endtask

  task automatic model_byte(input logic [26:0] a, input logic [7:0] d);
    logic [23:0] w;
    w = m_base + a[24:1];
    if (!m_accept) return;
    if (!a[0]) begin
      if (m_vld) exp_q.push_back(exp_t'({m_addr, 8'h00, m_byte, 2'b01}));
      m_vld  = 1'b1;
      m_addr = w;
      m_byte = d;
    end else if (m_vld && m_addr == w) begin
      exp_q.push_back(exp_t'({w, d, m_byte, 2'b11}));
      m_vld = 1'b0;
    end else if (m_vld) begin
      exp_q.push_back(exp_t'({m_addr, 8'h00, m_byte, 2'b01}));
      m_vld = 1'b0;
    end else begin
      exp_q.push_back(exp_t'({w, d, 8'h00, 2'b10}));
    end
  endtask

  task automatic wr_byte(input logic [26:0] a, input logic [7:0] d);
    addr = a;
    dout = d;
    wr   = 1'b1;
    tick(1);
    wr   = 1'b0;
  endtask

  // Behaves like the download stage: deliver one cycle after clkref_n is seen low.
  task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
    int n;
    n = 0;
    while (clkref_m !== 1'b0 && n < 1000) begin tick(1); n++; end
    check_eq("clkref_wait", 64'(clkref_m), 64'd0);
    tick(1);
    wr_byte(a, d);
    model_byte(a, d);
  endtask

  task automatic end_download();
    dl = 1'b0;
    if (m_vld) exp_q.push_back(exp_t'({m_addr, 8'h00, m_byte, 2'b01}));
    m_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == done_base && n < 3000) begin tick(1); n++; end
    tick(4);
    check_eq({tag, "_done"}, 64'(done_cnt - done_base), 64'd1);
  endtask

  int lo_cnt, req_seen;
  logic [7:0] t1_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    reset = 1'b1; dl = 1'b0; wr = 1'b0; sel = 1'b0; idx = 8'h00; dout = 8'h00;
    addr = '0; ack_m = 1'b0; ack_hold = 1'b0; ack_delay = 2;
    m_vld = 1'b0; m_accept = 1'b1; m_base = 24'h0; m_addr = '0; m_byte = '0;
    tick(3);
    reset = 1'b0;

    // Reset values
    check_eq("rst_clkref_n", 64'(clkref_m), 64'd1);
    check_eq("rst_req", 64'(req_m), 64'd0);
    check_eq("rst_addr", 64'(addr_m), 64'd0);
    check_eq("rst_din", 64'(din_m), 64'd0);
    check_eq("rst_be", 64'(be_m), 64'd0);
    check_eq("rst_busy", 64'(busy_m), 64'd0);
    check_eq("rst_done", 64'(done_m), 64'd0);
    check_eq("rst_ovf", 64'(ovf_m), 64'd0);

    // 1: four bytes -> two full words
    begin_test();
    dl = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(27'(i), t1_bytes[i]);
    check_eq("t1_busy", 64'(busy_m), 64'd1);
    end_download();
    wait_done("t1");
    check_eq("t1_writes", 64'(wr_cnt - wr_base), 64'd2);
    check_eq("t1_ovf", 64'(ovf_m), 64'd0);
    check_eq("t1_sb_empty", 64'(exp_q.size()), 64'd0);
    check_eq("t1_busy_end", 64'(busy_m), 64'd0);

    // 2: base offset, odd-length file; last byte written only at download end
    pulse_reset();
    sel = 1'b1; idx = 8'h02; m_base = 24'h100000;
    begin_test();
    dl = 1'b1;
    send_byte(27'd0, 8'hAA);
    send_byte(27'd1, 8'hBB);
    send_byte(27'd2, 8'hCC);
    tick(20);
    check_eq("t2_writes_mid", 64'(wr_cnt - wr_base), 64'd1);
    check_eq("t2_no_done_mid", 64'(done_cnt - done_base), 64'd0);
    check_eq("t2_busy_mid", 64'(busy_m), 64'd1);
    end_download();
    wait_done("t2");
    check_eq("t2_writes", 64'(wr_cnt - wr_base), 64'd2);
    check_eq("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // 3: SDRAM stalled 200 cycles during a 64-byte download
    pulse_reset();
    sel = 1'b0; idx = 8'h00; m_base = 24'h0; ack_delay = 1;
    begin_test();
    dl = 1'b1;
    lo_cnt = 0;
    ack_hold = 1'b1;
    fork
      for (int i = 0; i < 64; i++) send_byte(27'(i), 8'(i * 3 + 1));
      begin
        repeat (100) @(negedge clk_sys);
        repeat (100) begin
          @(negedge clk_sys);
          if (clkref_m !== 1'b1) lo_cnt++;
        end
        ack_hold = 1'b0;
      end
    join
    check_eq("t3_clkref_hold", 64'(lo_cnt), 64'd0);
    end_download();
    wait_done("t3");
    check_eq("t3_writes", 64'(wr_cnt - wr_base), 64'd32);
    check_eq("t3_ovf", 64'(ovf_m), 64'd0);
    check_eq("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // 4a: index mismatch -> no writes, done still pulses
    pulse_reset();
    sel = 1'b1; idx = 8'h05; m_base = 24'h100000; m_accept = 1'b0; ack_delay = 2;
    begin_test();
    dl = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(27'(i), 8'(8'h50 + i));
    end_download();
    wait_done("t4a");
    check_eq("t4a_writes", 64'(wr_cnt - wr_base), 64'd0);

    // 4b: index 0x42 matches in its low six bits
    m_accept = 1'b1; idx = 8'h42;
    tick(2);
    begin_test();
    dl = 1'b1;
    for (int i = 4; i < 8; i++) send_byte(27'(i), 8'(8'h70 + i));
    end_download();
    wait_done("t4b");
    check_eq("t4b_writes", 64'(wr_cnt - wr_base), 64'd2);
    check_eq("t4b_sb_empty", 64'(exp_q.size()), 64'd0);

    // 5: reset with a request outstanding and three words queued
    pulse_reset();
    sel = 1'b0; idx = 8'h00; m_base = 24'h0;
    begin_test();
    ack_hold = 1'b1;
    dl = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(27'(i), 8'(8'h30 + i));
    tick(3);
    check_eq("t5_req_before", 64'(req_m), 64'd1);
    check_eq("t5_clkref_before", 64'(clkref_m), 64'd1);
    reset = 1'b1;
    dl = 1'b0;
    tick(1);
    reset = 1'b0;
    check_eq("t5_req_after", 64'(req_m), 64'd0);
    check_eq("t5_busy_after", 64'(busy_m), 64'd0);
    check_eq("t5_clkref_after", 64'(clkref_m), 64'd1);
    exp_q.delete();
    m_vld = 1'b0;
    ack_hold = 1'b0;
    ack_m = 1'b1;
    tick(1);
    ack_m = 1'b0;
    req_seen = 0;
    repeat (10) begin
      tick(1);
      if (req_m !== 1'b0) req_seen++;
    end
    check_eq("t5_no_req_late_ack", 64'(req_seen), 64'd0);
    check_eq("t5_no_done", 64'(done_cnt - done_base), 64'd0);
    check_eq("t5_no_write", 64'(wr_cnt - wr_base), 64'd0);

    // 6: forced bytes into a full FIFO -> sticky overflow, contents intact
    pulse_reset();
    begin_test();
    ack_hold = 1'b1;
    dl = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(27'(i), 8'(8'h60 + i));
    tick(3);
    check_eq("t6_clkref_3used", 64'(clkref_m), 64'd1);
    wr_byte(27'd6, 8'h66);
    wr_byte(27'd7, 8'h67);
    exp_q.push_back(exp_t'({24'd3, 8'h67, 8'h66, 2'b11}));
    check_eq("t6_ovf_at_full", 64'(ovf_m), 64'd0);
    wr_byte(27'd8, 8'h68);
    wr_byte(27'd9, 8'h69);
    tick(1);
    check_eq("t6_ovf_set", 64'(ovf_m), 64'd1);
    ack_hold = 1'b0;
    end_download();
    wait_done("t6");
    check_eq("t6_writes", 64'(wr_cnt - wr_base), 64'd4);
    check_eq("t6_sb_empty", 64'(exp_q.size()), 64'd0);
    check_eq("t6_ovf_sticky", 64'(ovf_m), 64'd1);
    pulse_reset();
    check_eq("t6_ovf_cleared", 64'(ovf_m), 64'd0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ioctl_sdram_loader.md
Name: ioctl_sdram_loader

Overview:
- Sits directly downstream of the SPI file-download stage (ioctl_* byte stream) and upstream of the SDRAM controller's loader port.
- Packs incoming download bytes into 16-bit little-endian words with byte enables and buffers them in a small FIFO.
- Issues req/ack write transactions to SDRAM.
- Throttles the download via clkref_n, so no byte is ever dropped regardless of SDRAM latency.

Parameters:
- DEPTH, 4: FIFO entries (power of two, >=2).
- BASE_WORD, 24'h000000: SDRAM word address added to every download word address.
- INDEX, 6'h3F: accepted ioctl_index[5:0]; 6'h3F accepts any index.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download active level from the download stage.
- ioctl_index  in  8  menu/file index; bits [5:0] compared with INDEX.
- ioctl_wr  in  1  one-cycle byte-valid strobe.
- ioctl_addr  in  27  byte address of ioctl_dout.
- ioctl_dout  in  8  download byte.
- clkref_n  out  1  low = a byte may be delivered (download stage writes one cycle after seeing it low).
- sdram_req  out  1  write request, held until ack.
- sdram_addr  out  24  word address.
- sdram_din  out  16  write data; [7:0] is the even byte.
- sdram_be  out  2  byte enables; [0] = low byte.
- sdram_ack  in  1  one-cycle completion pulse.
- loader_busy  out  1  high from download start until the last word is acked.
- loader_done  out  1  one-cycle pulse when a download fully lands in SDRAM.
- overflow  out  1  sticky; a push was attempted while the FIFO was full.

Behaviour:
- Reset values:
  - clkref_n=1; sdram_req=0; sdram_addr=0; sdram_din=0; sdram_be=0.
  - loader_busy=0; loader_done=0; overflow=0.
  - FIFO empty; pending register invalid; state IDLE.
- Reset asserted mid-transfer discards FIFO contents and any outstanding request immediately. The ack of an aborted request is ignored.
- Acceptance: a byte is accepted when ioctl_wr=1, ioctl_download=1 and the index matches (INDEX==6'h3F, or ioctl_index[5:0]==INDEX). Bytes that are not accepted are ignored.
- Word address: waddr = BASE_WORD + ioctl_addr[24:1], modulo 2^24 (wraps silently).
- Packing, with a single pending register {waddr, low byte, valid}. At most one FIFO push per cycle.
  - Even byte, no pending: store as pending.
  - Even byte, pending valid: push pending with be=01; the new byte becomes pending.
  - Odd byte, pending valid, same waddr: push {odd, pending} with be=11; clear pending.
  - Odd byte, pending valid, different waddr: push pending with be=01; the odd byte is lost. This is illegal ordering; set overflow.
  - Odd byte, no pending: push {odd, 8'h00} with be=10.
- Throttle: clkref_n=0 only when FIFO free entries >= 2 and the state is LOAD; otherwise 1. Evaluated combinationally from the registered count. Any push into a full FIFO is dropped and sets overflow.
- State machine:
  - IDLE: on ioctl_download rising (registered edge detect) -> LOAD; loader_busy=1.
  - LOAD: on ioctl_download falling -> FLUSH.
  - FLUSH: if pending is valid, push it with be=01 (one cycle, waits if the FIFO is full) -> DRAIN.
  - DRAIN: when FIFO is empty and no request is outstanding -> IDLE, with loader_done=1 for one cycle and loader_busy=0.
  - A rising ioctl_download in FLUSH or DRAIN is held until IDLE is re-entered; it then starts a new LOAD in the following cycle.
- SDRAM handshake:
  - When the FIFO is non-empty and sdram_req=0, the next cycle sets sdram_req=1 with addr/din/be from the FIFO head. Latency from push to req is 2 cycles minimum.
  - Outputs stay stable while sdram_req=1.
  - On sdram_ack: pop, sdram_req=0 for at least one cycle.
  - Ack while req=0 is ignored.
- Simultaneous push and pop in one cycle is allowed; the count is unchanged.

Test Plan:
1. Reset, download bytes 0x11,0x22,0x33,0x44 at addr 0..3, ack 3 cycles after each req -> two writes: addr 0 din 0x2211 be 11, addr 1 din 0x4433 be 11; loader_done pulses once after the second ack; overflow=0.
2. BASE_WORD=24'h100000, odd-length file of 3 bytes 0xAA,0xBB,0xCC -> writes 0x100000/0xBBAA/11, then on download end 0x100001/0x00CC/01; done only after final ack.
3. Hold sdram_ack low for 200 cycles during a 64-byte download -> clkref_n stays 1 once the FIFO has <2 free entries; all 32 words arrive in order; overflow=0.
4. INDEX=6'h02, stream with ioctl_index=8'h05 -> no sdram_req, loader_done still pulses at end; repeat with index 8'h42 -> writes occur.
5. Assert reset while sdram_req=1 and FIFO holds 3 entries -> next cycle sdram_req=0, loader_busy=0, clkref_n=1; a late ack causes no pop and no done pulse.
6. Force ioctl_wr while clkref_n=1 with FIFO full -> overflow=1 and stays set until reset; the FIFO contents are unaltered.
